// File: rtl/mem_share_vn_iblut_rank_ld.sv
// IB lookup RAM rank for a VN share group: one RAM per channel, run-time
// sharing degree per channel, two-stage read pipeline and a handshaked load engine.
module mem_share_vn_iblut_rank_ld #(
  parameter int CH_NUM        = 4,
  parameter int QUAN_SIZE     = 4,
  parameter int COL_SEL_WIDTH = 2,
  parameter int CFG_W         = $clog2(COL_SEL_WIDTH + 1),
  parameter int DEPTH         = 2 ** (COL_SEL_WIDTH + QUAN_SIZE)
) (
  input  logic                            sys_clk,
  input  logic                            rstn,
  input  logic [CFG_W*CH_NUM-1:0]         cfg_colsel_bits_i,
  input  logic                            rd_valid_i,
  output logic                            rd_ready_o,
  input  logic [COL_SEL_WIDTH*CH_NUM-1:0] colsel_vec_i,
  input  logic [QUAN_SIZE*CH_NUM-1:0]     c2v_msg_vec_i,
  output logic                            v2c_valid_o,
  output logic [QUAN_SIZE*CH_NUM-1:0]     v2c_msg_vec_o,
  input  logic                            remap_en_n,
  input  logic [CH_NUM-1:0]               load_ch_mask_i,
  input  logic                            load_valid_i,
  output logic                            load_ready_o,
  input  logic [QUAN_SIZE-1:0]            load_data_i,
  output logic                            load_done_o,
  output logic                            load_busy_o
);

  localparam int AW = COL_SEL_WIDTH + QUAN_SIZE;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; ready never depends on valid, and valid may be raised at any time.
  logic rd_ready_q, load_ready_q, load_done_q, load_busy_q;
  logic rd_fire, load_fire;

  assign rd_fire   = rd_valid_i && rd_ready_q;
  assign load_fire = load_valid_i && load_ready_q;

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!remap_en_n) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (load_fire) cnt_d = cnt_q + AW'(1);
        // Abort wins over the final beat; the beat itself is still written.
        if (remap_en_n) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (load_fire && (cnt_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (remap_en_n) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags are registered copies of the next state so every output is
  // zero while reset is held and tracks the state register afterwards.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      rd_ready_q   <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_busy_q  <= 1'b0;
    end else begin
      rd_ready_q   <= (state_d == ST_IDLE);
      load_ready_q <= (state_d == ST_LOAD);
      load_done_q  <= (state_d == ST_DONE);
      load_busy_q  <= (state_d == ST_LOAD);
    end
  end

  assign rd_ready_o   = rd_ready_q;
  assign load_ready_o = load_ready_q;
  assign load_done_o  = load_done_q;
  assign load_busy_o  = load_busy_q;

  // ---------------------------------------------------------------------------
  // Address generation: keep the low min(cfg, COL_SEL_WIDTH) column-select bits
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0][COL_SEL_WIDTH-1:0] keep_mask;
  logic [CH_NUM-1:0][AW-1:0]            addr_d;

  always_comb begin
    keep_mask = '0;
    addr_d    = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      for (int b = 0; b < COL_SEL_WIDTH; b++) begin
        keep_mask[k][b] = (int'(cfg_colsel_bits_i[k*CFG_W +: CFG_W]) > b);
      end
      addr_d[k] = {colsel_vec_i[k*COL_SEL_WIDTH +: COL_SEL_WIDTH] & keep_mask[k],
                   c2v_msg_vec_i[k*QUAN_SIZE +: QUAN_SIZE]};
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline stage 1: registered addresses
  // ---------------------------------------------------------------------------
  logic                      s1_valid_q;
  logic [CH_NUM-1:0][AW-1:0] s1_addr_q;
  logic                      s2_valid_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) s1_addr_q <= addr_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  assign v2c_valid_o = s2_valid_q;

  // ---------------------------------------------------------------------------
  // Per-channel RAM and stage 2 output register (read-first on collision)
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [QUAN_SIZE-1:0] mem_q [DEPTH];
    logic [QUAN_SIZE-1:0] rd_data_q;

    always_ff @(posedge sys_clk) begin
      if (load_fire && load_ch_mask_i[k]) mem_q[cnt_q] <= load_data_i;
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
        rd_data_q <= '0;
      end else if (s1_valid_q) begin
        rd_data_q <= mem_q[s1_addr_q[k]];
      end
    end

    assign v2c_msg_vec_o[k*QUAN_SIZE +: QUAN_SIZE] = rd_data_q;
  end

endmodule

// File: tb/tb_mem_share_vn_iblut_rank_ld.sv
// Bench for mem_share_vn_iblut_rank_ld: behavioural RAM/load model checked every
// cycle, plus directed reads with hand-computed results.
module tb_mem_share_vn_iblut_rank_ld;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_DONE = 2;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic [7:0]  cfg_colsel_bits_i;
  logic        rd_valid_i;
  logic        rd_ready_o;
  logic [7:0]  colsel_vec_i;
  logic [15:0] c2v_msg_vec_i;
  logic        v2c_valid_o;
  logic [15:0] v2c_msg_vec_o;
  logic        remap_en_n;
  logic [3:0]  load_ch_mask_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic [3:0]  load_data_i;
  logic        load_done_o;
  logic        load_busy_o;

  int n_vec  = 0;
  int n_fail = 0;

  mem_share_vn_iblut_rank_ld dut (
    .sys_clk           (sys_clk),
    .rstn              (rstn),
    .cfg_colsel_bits_i (cfg_colsel_bits_i),
    .rd_valid_i        (rd_valid_i),
    .rd_ready_o        (rd_ready_o),
    .colsel_vec_i      (colsel_vec_i),
    .c2v_msg_vec_i     (c2v_msg_vec_i),
    .v2c_valid_o       (v2c_valid_o),
    .v2c_msg_vec_o     (v2c_msg_vec_o),
    .remap_en_n        (remap_en_n),
    .load_ch_mask_i    (load_ch_mask_i),
    .load_valid_i      (load_valid_i),
    .load_ready_o      (load_ready_o),
    .load_data_i       (load_data_i),
    .load_done_o       (load_done_o),
    .load_busy_o       (load_busy_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: RAM contents as arrays, read results as a two-edge delay
  // ---------------------------------------------------------------------------
  logic [3:0] mm [4][64];
  bit         mk [4][64];
  int         m_state;
  int         m_cnt;
  bit         p1_valid;
  int         p1_addr [4];
  bit         e_rd_ready, e_load_ready, e_done, e_busy, e_valid;
  logic [3:0] e_data [4];
  bit         e_known [4];

  task automatic m_reset();
    m_state = S_IDLE;
    m_cnt = 0;
    p1_valid = 0;
    e_rd_ready = 0; e_load_ready = 0; e_done = 0; e_busy = 0; e_valid = 0;
    for (int c = 0; c < 4; c++) begin
      e_data[c] = 4'h0;
      e_known[c] = 1;
    end
  endtask

  task automatic m_step();
    bit acc, beat;
    acc  = rd_valid_i && e_rd_ready;
    beat = load_valid_i && e_load_ready;
    e_valid = p1_valid;
    if (p1_valid) begin
      for (int c = 0; c < 4; c++) begin
        e_data[c]  = mm[c][p1_addr[c]];
        e_known[c] = mk[c][p1_addr[c]];
      end
    end
    p1_valid = acc;
    if (acc) begin
      for (int c = 0; c < 4; c++) begin
        int cf, eff, cs, lo;
        cf  = int'(cfg_colsel_bits_i[c*2 +: 2]);
        eff = (cf > 2) ? 2 : cf;
        cs  = int'(colsel_vec_i[c*2 +: 2]);
        lo  = int'(c2v_msg_vec_i[c*4 +: 4]);
        p1_addr[c] = (cs % (1 << eff)) * 16 + lo;
      end
    end
    if (beat) begin
      for (int c = 0; c < 4; c++) begin
        if (load_ch_mask_i[c]) begin
          mm[c][m_cnt] = load_data_i;
          mk[c][m_cnt] = 1;
        end
      end
      m_cnt++;
    end
    case (m_state)
      S_IDLE: if (!remap_en_n) begin m_state = S_LOAD; m_cnt = 0; end
      S_LOAD: begin
        if (remap_en_n) begin m_state = S_IDLE; m_cnt = 0; end
        else if (m_cnt == 64) m_state = S_DONE;
      end
      default: if (remap_en_n) m_state = S_IDLE;
    endcase
    e_rd_ready   = (m_state == S_IDLE);
    e_load_ready = (m_state == S_LOAD);
    e_busy       = (m_state == S_LOAD);
    e_done       = (m_state == S_DONE);
  endtask

  initial begin
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 64; a++) begin
        mm[c][a] = 4'h0;
        mk[c][a] = 0;
      end
    m_reset();
    forever begin
      @(posedge sys_clk or negedge rstn);
      if (!rstn) m_reset();
      else m_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare, once per cycle away from the active edge
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge sys_clk);
      #1;
      chk("rd_ready", rd_ready_o, e_rd_ready);
      chk("load_ready", load_ready_o, e_load_ready);
      chk("load_busy", load_busy_o, e_busy);
      chk("load_done", load_done_o, e_done);
      chk("v2c_valid", v2c_valid_o, e_valid);
      for (int c = 0; c < 4; c++)
        if (e_known[c]) chk($sformatf("v2c_ch%0d", c), v2c_msg_vec_o[c*4 +: 4], e_data[c]);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] beat_data(input int kind, input int i);
    case (kind)
      0:       return 4'(i % 16);
      1:       return 4'(i >> 2);
      2:       return 4'hA;
      3:       return 4'h7;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic rand_read_inputs();
    cfg_colsel_bits_i = 8'($urandom);
    colsel_vec_i      = 8'($urandom);
    c2v_msg_vec_i     = 16'($urandom);
  endtask

  // throttle: 0 every cycle, 1 every other cycle, 2 random; abort_after 0 = full load
  task automatic do_load(input logic [3:0] mask, input int kind, input int throttle,
                         input int abort_after);
    int beats, cyc, target;
    bit lv, lr;
    target = (abort_after > 0) ? abort_after : 64;
    @(negedge sys_clk);
    remap_en_n = 1'b0;
    load_ch_mask_i = mask;
    load_valid_i = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < target && cyc < 1000) begin
      @(negedge sys_clk);
      lr = load_ready_o;
      if (lr) chk("rd_ready_in_load", rd_ready_o, 0);
      case (throttle)
        0:       lv = 1'b1;
        1:       lv = cyc[0];
        default: lv = 1'($urandom_range(0, 1));
      endcase
      load_valid_i = lv;
      load_data_i  = beat_data(kind, beats);
      @(posedge sys_clk);
      if (lv && lr) beats++;
      cyc++;
    end
    chk("load_beats", beats, target);
    @(negedge sys_clk);
    load_valid_i = 1'b0;
    if (abort_after > 0) begin
      remap_en_n = 1'b1;
      @(negedge sys_clk);
      chk("abort_busy", load_busy_o, 0);
      chk("abort_done", load_done_o, 0);
      chk("abort_rd_ready", rd_ready_o, 1);
    end else begin
      chk("full_done", load_done_o, 1);
      @(negedge sys_clk);
      chk("done_hold", load_done_o, 1);
      remap_en_n = 1'b1;
      @(negedge sys_clk);
      chk("done_exit_rd_ready", rd_ready_o, 1);
    end
  endtask

  task automatic rd_lit(input string nm, input logic [7:0] cfg, input logic [7:0] cs,
                        input logic [15:0] c2v, input logic [15:0] expv);
    int w;
    @(negedge sys_clk);
    rd_valid_i = 1'b1;
    cfg_colsel_bits_i = cfg;
    colsel_vec_i = cs;
    c2v_msg_vec_i = c2v;
    @(negedge sys_clk);
    rd_valid_i = 1'b0;
    @(posedge sys_clk);
    #1;
    w = 0;
    while (v2c_valid_o !== 1'b1 && w < 4) begin
      @(posedge sys_clk);
      #1;
      w++;
    end
    chk({nm, "_valid_latency"}, w, 0);
    chk({nm, "_data"}, v2c_msg_vec_o, expv);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rstn = 1'b0;
    cfg_colsel_bits_i = 8'h0;
    rd_valid_i = 1'b0;
    colsel_vec_i = 8'h0;
    c2v_msg_vec_i = 16'h0;
    remap_en_n = 1'b1;
    load_ch_mask_i = 4'h0;
    load_valid_i = 1'b0;
    load_data_i = 4'h0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_rd_ready", rd_ready_o, 0);
    chk("rst_v2c_valid", v2c_valid_o, 0);
    chk("rst_v2c_msg", v2c_msg_vec_o, 0);
    chk("rst_load_busy", load_busy_o, 0);
    @(negedge sys_clk);
    rstn = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_rd_ready", rd_ready_o, 1);

    // Reset in the middle of a read stream
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      rd_valid_i = 1'b1;
      rand_read_inputs();
    end
    @(negedge sys_clk);
    rstn = 1'b0;
    #1;
    chk("midrst_rd_ready", rd_ready_o, 0);
    chk("midrst_v2c_valid", v2c_valid_o, 0);
    chk("midrst_v2c_msg", v2c_msg_vec_o, 0);
    chk("midrst_load_ready", load_ready_o, 0);
    chk("midrst_load_done", load_done_o, 0);
    chk("midrst_load_busy", load_busy_o, 0);
    @(negedge sys_clk);
    rstn = 1'b1;
    rd_valid_i = 1'b0;
    @(negedge sys_clk);
    chk("midrst_release_rd_ready", rd_ready_o, 1);
    chk("midrst_release_busy", load_busy_o, 0);

    // Full load with data = i%16, then directed readbacks
    do_load(4'hF, 0, 0, 0);
    rd_lit("entry37", 8'hAA, 8'hAA, 16'h5555, 16'h5555);
    rd_lit("share_mod16", 8'hE4, 8'hFF, 16'h3333, 16'h3333);

    // Eight back-to-back reads, load request on the last acceptance
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      rd_valid_i = 1'b1;
      rand_read_inputs();
      if (i == 7) remap_en_n = 1'b0;
    end
    @(negedge sys_clk);
    rd_valid_i = 1'b0;
    do_load(4'hF, 1, 0, 0);
    rd_lit("share_div4", 8'hE4, 8'hFF, 16'h3333, 16'hCC40);

    // Throttled, masked load
    do_load(4'h5, 2, 1, 0);
    rd_lit("masked_entry37", 8'hAA, 8'hAA, 16'h5555, 16'h9A9A);

    // Abort after ten beats
    do_load(4'hF, 3, 0, 10);
    rd_lit("abort_entry9", 8'hAA, 8'h00, 16'h9999, 16'h7777);
    rd_lit("abort_entry10", 8'hAA, 8'h00, 16'hAAAA, 16'h2A2A);
    rd_lit("abort_entry0_gp1", 8'h00, 8'hFF, 16'h0000, 16'h7777);

    // Random reads with random configs, interleaved with random loads
    for (int r = 0; r < 3; r++) begin
      repeat (80) begin
        @(negedge sys_clk);
        rd_valid_i = 1'($urandom_range(0, 1));
        rand_read_inputs();
      end
      @(negedge sys_clk);
      rd_valid_i = 1'b0;
      do_load(4'($urandom_range(0, 15)), 4, 2, (r == 1) ? $urandom_range(1, 63) : 0);
    end
    repeat (4) @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_share_vn_iblut_rank_ld.md
Name: mem_share_vn_iblut_rank_ld

Overview:
- Next-generation IB-RAM rank for the column-bank sharing scheme. Holds one IB lookup RAM per VN channel in a share group.
- Per-channel sharing degree is set at run time, replacing the fixed GP1/GP2 build-time split.
- Adds an integrated remap/load engine with a valid/ready handshake, and a pipelined read path with valid tagging.
- Sits between the C2V message network and the VN update stage of the layered LDPC decoder.

Parameters:
- CH_NUM, 4: number of VN channels (share-group size).
- QUAN_SIZE, 4: message width in bits; also the low address field.
- COL_SEL_WIDTH, 2: maximum column-select bits per channel (maximum sharing 2^COL_SEL_WIDTH).
- CFG_W, $clog2(COL_SEL_WIDTH+1): width of the per-channel sharing-degree field.
- DEPTH, 2^(COL_SEL_WIDTH+QUAN_SIZE): entries per channel RAM (derived; do not override).

Ports:
- sys_clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_colsel_bits_i  in  CFG_W*CH_NUM  per-channel count of active column-select bits; value 0 means GP1, 1 means GP2, 2 means GP4.
- rd_valid_i  in  1  read request.
- rd_ready_o  out  1  read accept.
- colsel_vec_i  in  COL_SEL_WIDTH*CH_NUM  per-channel column select.
- c2v_msg_vec_i  in  QUAN_SIZE*CH_NUM  per-channel C2V message.
- v2c_valid_o  out  1  read data valid.
- v2c_msg_vec_o  out  QUAN_SIZE*CH_NUM  per-channel V2C message.
- remap_en_n  in  1  active-low load request (level).
- load_ch_mask_i  in  CH_NUM  channels written by the load engine.
- load_valid_i  in  1  load word valid.
- load_ready_o  out  1  load word accept.
- load_data_i  in  QUAN_SIZE  load word.
- load_done_o  out  1  high while in DONE.
- load_busy_o  out  1  high while in LOAD.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, load counter 0, pipeline valids 0. RAM contents are not reset and are undefined until loaded.
- Address per channel k:
  - addr = {colsel_k AND mask_k, c2v_k}.
  - mask_k keeps the low min(cfg_k, COL_SEL_WIDTH) bits of colsel_k; cfg values above COL_SEL_WIDTH saturate.
  - Masked bits read as 0, so a GP1 channel always addresses entries 0..2^QUAN_SIZE-1.
- Read pipeline:
  - rd_ready_o = (state==IDLE). A read is accepted on a clock edge with rd_valid_i && rd_ready_o.
  - Stage 1 registers the addresses. Stage 2 registers the RAM outputs.
  - v2c_valid_o and data appear exactly 2 cycles after acceptance. Throughput is one read per cycle; there is no output backpressure.
  - v2c_msg_vec_o holds its last value when v2c_valid_o is low.
  - Reads accepted before leaving IDLE always complete, and return pre-write data.
  - The config is sampled at acceptance; a config change affects only later reads.
- Load FSM:
  - IDLE -> LOAD when remap_en_n==0. The counter is cleared on entry.
  - In LOAD, load_ready_o=1. Each beat (load_valid_i && load_ready_o) writes load_data_i to entry[counter] of every channel whose load_ch_mask_i bit is set, then counter++.
  - load_ch_mask_i is sampled per beat. A mask of 0 still advances the counter.
  - The beat at counter==DEPTH-1 moves LOAD -> DONE.
  - In DONE, load_done_o=1 and load_ready_o=0. DONE -> IDLE when remap_en_n==1. If remap_en_n stays low, the FSM stays in DONE with no auto-reload.
  - remap_en_n rising during LOAD aborts: LOAD -> IDLE next cycle and the counter is cleared. Entries already written keep their new values, and a beat coinciding with the abort edge is still written.
- RAM is read-first: a same-cycle write and stage-2 read to one address returns the old data.
- Reset asserted mid-load: FSM returns to IDLE and the counter is cleared; RAM keeps partial contents.

Test Plan (CH_NUM=4, QUAN_SIZE=4, COL_SEL_WIDTH=2, DEPTH=64):
- Reset mid-stream: assert rstn=0 during reads -> all outputs 0 the same cycle; after release rd_ready_o=1 and load_busy_o=0.
- Full load and readback:
  - Stimulus: remap_en_n=0, mask=4'b1111, 64 beats with data=i%16.
  - Required: load_done_o=1 after beat 63, rd_ready_o=0 throughout LOAD.
  - Then: remap_en_n=1 and read colsel=2'b10, c2v=4'h5 with cfg=2 on all channels -> entry 37 -> 4'h5 on every channel, 2 cycles after acceptance.
- Sharing degree: same load, cfg={0,1,2,3}, colsel=2'b11, c2v=4'h3 -> addresses 3, 19, 51, 51 -> outputs 3, 3, 3, 3. Repeat with data=i>>2 -> outputs 0, 4, 12, 12.
- Throttled load with mask:
  - Stimulus: mask=4'b0101, load_valid_i toggled every other cycle, data=4'hA.
  - Required: 64 beats complete; channels 0 and 2 read 4'hA, channels 1 and 3 unchanged.
- Abort: remap_en_n high after 10 beats -> IDLE next cycle, load_done_o never asserted, entries 0..9 new, entry 10 old.
- Back-to-back reads: 8 consecutive reads with remap_en_n asserted on the last one -> all 8 return pre-load data on consecutive cycles; v2c_valid_o deasserts 2 cycles after the last acceptance.
